// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite draw scheduler.
// Engine indices, default widths and the scheduler state encoding.
package sprite_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    GRANT,
    RELEASE,
    DONE
  } state_t;

  localparam int REQ_PLAYER = 0;
  localparam int REQ_ALIEN  = 1;
  localparam int REQ_BULLET = 2;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_X_W     = 9;
  localparam int DEF_Y_W     = 8;
  localparam int DEF_C_W     = 3;
  localparam int DEF_TIMEOUT = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_pick.sv
// Pending-mask encoder: first set bit at or after start, wrapping.
// With start tied to zero it is a plain lowest-index priority encoder.
import sprite_sched_pkg::*;

module sched_pick #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int j;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && pending[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Frame scheduler time-multiplexing one pixel-plot port between engines.
// Define SPRITE_SCHED_RR_EN for round-robin start rotation per round.
import sprite_sched_pkg::*;

module sprite_draw_scheduler #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     grant,
  input  logic [NUM_REQ-1:0]     px_valid,
  input  logic [NUM_REQ-1:0]     px_last,
  input  logic [NUM_REQ*X_W-1:0] px_x,
  input  logic [NUM_REQ*Y_W-1:0] px_y,
  input  logic [NUM_REQ*C_W-1:0] px_colour,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int IW   = idx_w(NUM_REQ);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [IW-1:0]      cur;
  logic [WD_W-1:0]    wd;
  logic [IW-1:0]      start;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               cur_valid;
  logic               cur_last;

`ifdef SPRITE_SCHED_RR_EN
  logic [IW-1:0] ptr;
  assign start = ptr;
`else
  assign start = '0;
`endif

  sched_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .pending (pending),
    .start   (start),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign cur_valid = px_valid[cur];
  assign cur_last  = px_last[cur];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      cur         <= '0;
      wd          <= '0;
      grant       <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef SPRITE_SCHED_RR_EN
      ptr         <= '0;
`endif
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            pending <= req;
            state   <= SELECT;
          end
        end
        SELECT: begin
          if (!pick_found) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            cur   <= pick_idx;
            grant <= ONE << pick_idx;
            wd    <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (cur_valid) begin
            x      <= px_x[cur*X_W +: X_W];
            y      <= px_y[cur*Y_W +: Y_W];
            colour <= px_colour[cur*C_W +: C_W];
            plot   <= 1'b1;
            wd     <= '0;
            if (cur_last) state <= RELEASE;
          end else if (wd == WD_MAX) begin
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        // grant falls on leaving RELEASE, so SELECT is the dead cycle
        RELEASE: begin
          grant        <= '0;
          pending[cur] <= 1'b0;
          state        <= SELECT;
        end
        DONE: begin
`ifdef SPRITE_SCHED_RR_EN
          ptr <= (ptr == IW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
